// File: rtl/adder_pkg.sv
// Shared constants for the registered adder family: overflow-mode encodings,
// the default operand width and the overflow-select helper.
package adder_pkg;

    localparam int OVF_UNSIGNED = 0;
    localparam int OVF_SIGNED   = 1;
    localparam int ADDER_W      = 4;

    // Signed overflow occurs exactly when the carry into the MSB differs from the carry out.
    function automatic logic ovf_flag(input int mode, input logic carry_msb, input logic carry_out);
        logic flag;
        flag = carry_out;
        if (mode == OVF_SIGNED) begin
            flag = carry_msb ^ carry_out;
        end
        return flag;
    endfunction

endpackage

// File: rtl/reg_adder_full_adder.sv
// One-bit full adder cell, the building block of the ripple-carry chain in reg_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/reg_adder.sv
// Registered two-operand adder: ripple-carry chain, overflow select and an output
// register with asynchronous clear. Outputs are registers only, with one cycle of latency.
module reg_adder
    import adder_pkg::*;
#(
    parameter int WIDTH    = ADDER_W,
    parameter int OVF_MODE = OVF_UNSIGNED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;
    logic [WIDTH-1:0] sum_reg;
    logic             ovf_reg;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .s    (sum_next[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // carry[WIDTH-1] is the carry into the MSB, carry[WIDTH] the carry out.
    assign ovf_next = ovf_flag(OVF_MODE, carry[WIDTH-1], carry[WIDTH]);

    // Sum and flag share one register enable so they always move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (en) begin
            sum_reg <= sum_next;
            ovf_reg <= ovf_next;
        end
    end

    assign sum      = sum_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_reg_adder.sv
// Self-checking bench for reg_adder: directed steps on 4-bit instances in both overflow
// modes, then a random sweep over 4- and 8-bit instances against an arithmetic model.
module tb_reg_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic [3:0] s0, s1;
    logic [7:0] s2, s3;
    logic       o0, o1, o2, o3;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_s[4];
    int exp_o[4];

    always #5 clk = ~clk;

    reg_adder #(.WIDTH(4), .OVF_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .a(a4), .b(b4), .sum(s0), .overflow(o0));
    reg_adder #(.WIDTH(4), .OVF_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .a(a4), .b(b4), .sum(s1), .overflow(o1));
    reg_adder #(.WIDTH(8), .OVF_MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .en(en), .a(a8), .b(b8), .sum(s2), .overflow(o2));
    reg_adder #(.WIDTH(8), .OVF_MODE(1)) u3 (.clk(clk), .rst_n(rst_n), .en(en), .a(a8), .b(b8), .sum(s3), .overflow(o3));

    // Reference: plain integer arithmetic, signed overflow judged by the representable range.
    function automatic void model(input int w, input int mode, input int av, input int bv,
                                  output int s, output int o);
        int full, half, sa, sb;
        full = 1 << w;
        half = full / 2;
        s    = (av + bv) % full;
        if (mode == 0) begin
            o = (av + bv >= full) ? 1 : 0;
        end else begin
            sa = (av >= half) ? av - full : av;
            sb = (bv >= half) ? bv - full : bv;
            o  = ((sa + sb < -half) || (sa + sb > half - 1)) ? 1 : 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input int expv);
        logic [7:0] e;
        e = 8'(expv);
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic chk_w4(input string tag, input int es, input int eo0, input int eo1);
        chk({tag, " u0.sum"}, {4'b0, s0}, es);
        chk({tag, " u0.ovf"}, {7'b0, o0}, eo0);
        chk({tag, " u1.sum"}, {4'b0, s1}, es);
        chk({tag, " u1.ovf"}, {7'b0, o1}, eo1);
        $display("step %-10s a=%0d b=%0d sum=%0d ovf_u=%0b ovf_s=%0b", tag, a4, b4, s0, o0, o1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int tab_a[7] = '{1, 3, 4, 7, 15, 15, 8};
    int tab_b[7] = '{0, 2, 4, 10, 15, 1, 8};
    int tab_s[7] = '{1, 5, 8, 1, 14, 0, 0};
    int tab_u[7] = '{0, 0, 0, 1, 1, 1, 1};
    int tab_v[7] = '{0, 0, 1, 0, 0, 0, 1};

    initial begin
        rst_n = 1'b0; en = 1'b1;
        a4 = 4'd5; b4 = 4'd5; a8 = 8'd5; b8 = 8'd5;

        // Reset held with a running clock and enabled operands.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_w4("reset", 0, 0, 0);
        end
        rst_n = 1'b1;
        tick();
        chk_w4("release", 10, 0, 1);
        chk("release u2.sum", s2, 10);
        chk("release u3.ovf", {7'b0, o3}, 0);

        // Basic, wrap-around and signed cases share one operand table.
        for (int i = 0; i < 7; i++) begin
            a4 = 4'(tab_a[i]); b4 = 4'(tab_b[i]);
            tick();
            chk_w4("table", tab_s[i], tab_u[i], tab_v[i]);
        end

        // Hold: outputs freeze while en is low, regardless of operands.
        a4 = 4'd3; b4 = 4'd2;
        tick();
        chk_w4("load", 5, 0, 0);
        en = 1'b0; a4 = 4'd9; b4 = 4'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_w4("hold", 5, 0, 0);
        end
        en = 1'b1;
        tick();
        chk_w4("resume", 2, 1, 1);

        // Asynchronous reset between edges clears outputs before the next edge.
        a4 = 4'd3; b4 = 4'd2;
        tick();
        chk_w4("preload", 5, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_w4("async", 0, 0, 0);
        tick();
        chk_w4("rst_edge", 0, 0, 0);
        en = 1'b0; rst_n = 1'b1;
        tick();
        chk_w4("rel_hold", 0, 0, 0);
        en = 1'b1;
        tick();
        chk_w4("rel_load", 5, 0, 0);

        // Random sweep from a known cleared state.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_s[k] = 0;
            exp_o[k] = 0;
        end
        for (int i = 0; i < 200; i++) begin
            en = ($urandom_range(0, 3) != 0);
            a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
            a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
            tick();
            if (en) begin
                model(4, 0, int'(a4), int'(b4), exp_s[0], exp_o[0]);
                model(4, 1, int'(a4), int'(b4), exp_s[1], exp_o[1]);
                model(8, 0, int'(a8), int'(b8), exp_s[2], exp_o[2]);
                model(8, 1, int'(a8), int'(b8), exp_s[3], exp_o[3]);
            end
            chk("rnd u0.sum", {4'b0, s0}, exp_s[0]);
            chk("rnd u0.ovf", {7'b0, o0}, exp_o[0]);
            chk("rnd u1.sum", {4'b0, s1}, exp_s[1]);
            chk("rnd u1.ovf", {7'b0, o1}, exp_o[1]);
            chk("rnd u2.sum", s2, exp_s[2]);
            chk("rnd u2.ovf", {7'b0, o2}, exp_o[2]);
            chk("rnd u3.sum", s3, exp_s[3]);
            chk("rnd u3.ovf", {7'b0, o3}, exp_o[3]);
            $display("rnd %0d en=%0b a4=%0d b4=%0d a8=%0d b8=%0d s4=%0d/%0b%0b s8=%0d/%0b%0b",
                     i, en, a4, b4, a8, b8, s0, o0, o1, s2, o2, o3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
